// File: rtl/note_beat_sequencer.sv
// note_beat_sequencer
//   Feeds the note-drop draw stage. A programmable down-counter divides clk
//   into beat ticks. On every beat one chart row, prefetched from a
//   synchronous chart ROM, is handed to the drop stage over a valid/ack slot.
//
//   Optional feature macro: LOOP_CHART_EN
//     defined   : the chart wraps from the last row back to row 0 and never
//                 reaches DONE.
//     undefined : the song ends in DONE after the last row's beat.
//
//   Handshake (o_notes_valid / i_notes_ack):
//     o_notes is loaded and o_notes_valid raised on the clock edge after a beat
//     seen in HOLD. While o_notes_valid is high, o_notes is stable unless a new
//     beat overwrites it. i_notes_ack is sampled on a rising edge; if
//     o_notes_valid was high at that edge, the slot is freed (valid drops) from
//     the next cycle. An ack while valid is low has no effect. If a beat load
//     and an ack land on the same edge, the ack frees the slot first, the new
//     row loads, and valid stays high without flagging an overrun.
//
//   o_state exposes the FSM state for debug (0 IDLE, 1 FETCH, 2 HOLD, 3 DONE).
module note_beat_sequencer #(
  parameter int TICKS_PER_BEAT = 12_500_000,
  parameter int LANES          = 5,
  parameter int CHART_LEN      = 64,
  parameter int ADDR_W         = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic [1:0]        i_speed,
  output logic [ADDR_W-1:0] o_chart_addr,
  input  logic [LANES-1:0]  i_chart_data,
  output logic              o_beat,
  output logic [LANES-1:0]  o_notes,
  output logic              o_notes_valid,
  input  logic              i_notes_ack,
  output logic              o_overrun,
  output logic              o_done,
  output logic [1:0]        o_state
);

  // Beat counter width; the reload value at i_speed=0 is TICKS_PER_BEAT-1,
  // which always fits in $clog2(TICKS_PER_BEAT) bits.
  localparam int CNT_W = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;

  // Per-speed reload values (period-1). TICKS_PER_BEAT >= 8 keeps the
  // shortest period (>>3) at one cycle or more.
  localparam logic [CNT_W-1:0] RELOAD_S0 = CNT_W'(TICKS_PER_BEAT - 1);
  localparam logic [CNT_W-1:0] RELOAD_S1 = CNT_W'((TICKS_PER_BEAT >> 1) - 1);
  localparam logic [CNT_W-1:0] RELOAD_S2 = CNT_W'((TICKS_PER_BEAT >> 2) - 1);
  localparam logic [CNT_W-1:0] RELOAD_S3 = CNT_W'((TICKS_PER_BEAT >> 3) - 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CHART_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] reload_val;
  logic [LANES-1:0] prefetch;
  logic             hold_entry;
  logic [LANES-1:0] row_now;
  logic             running;
  logic             running_next;
  logic             start_go;
  logic             tick;
  logic             beat_in_hold;
  logic             last_row;

  // Decode shared control terms used by the FSM and the datapath.
  always_comb begin
    running      = (state == S_FETCH) || (state == S_HOLD);
    running_next = (state_next == S_FETCH) || (state_next == S_HOLD);
    start_go     = ((state == S_IDLE) || (state == S_DONE)) && i_start;
    tick         = running && !i_pause && (beat_cnt == '0);
    beat_in_hold = (state == S_HOLD) && o_beat;
    last_row     = (o_chart_addr == LAST_ADDR);
    // The first HOLD cycle sees the ROM word directly; afterwards the latched copy.
    row_now      = hold_entry ? i_chart_data : prefetch;
  end

  // Select the counter reload value for the current speed setting.
  always_comb begin
    reload_val = RELOAD_S0;
    case (i_speed)
      2'd0:    reload_val = RELOAD_S0;
      2'd1:    reload_val = RELOAD_S1;
      2'd2:    reload_val = RELOAD_S2;
      2'd3:    reload_val = RELOAD_S3;
      default: reload_val = RELOAD_S0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (i_start) state_next = S_FETCH;
      end
      S_FETCH: begin
        state_next = S_HOLD;
      end
      S_HOLD: begin
        if (o_beat) begin
`ifdef LOOP_CHART_EN
          state_next = S_FETCH;
`else
          state_next = last_row ? S_DONE : S_FETCH;
`endif
        end
      end
      S_DONE: begin
        if (i_start) state_next = S_FETCH;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs: done flag and debug state view.
  always_comb begin
    o_done  = (state == S_DONE);
    o_state = state;
  end

  // Beat down-counter: load on start, reload on terminal count, freeze on pause.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt <= '0;
    end else if (start_go) begin
      beat_cnt <= reload_val;
    end else if (running && !i_pause) begin
      if (beat_cnt == '0) begin
        beat_cnt <= reload_val;
      end else begin
        beat_cnt <= beat_cnt - 1'b1;
      end
    end
  end

  // Registered beat pulse; suppressed when the song is leaving the run states.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_beat <= 1'b0;
    end else begin
      o_beat <= tick && running_next;
    end
  end

  // Chart address: restart at row 0, advance (or wrap) after each HOLD beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_chart_addr <= '0;
    end else if (start_go) begin
      o_chart_addr <= '0;
    end else if (beat_in_hold) begin
      if (!last_row) begin
        o_chart_addr <= o_chart_addr + 1'b1;
      end else begin
`ifdef LOOP_CHART_EN
        o_chart_addr <= '0;
`else
        o_chart_addr <= o_chart_addr;
`endif
      end
    end
  end

  // Prefetch register: capture the ROM row on the first HOLD cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_entry <= 1'b0;
      prefetch   <= '0;
    end else begin
      hold_entry <= (state == S_FETCH);
      if (hold_entry && (state == S_HOLD)) begin
        prefetch <= i_chart_data;
      end
    end
  end

  // Output slot: load a row on a beat, otherwise free it on a valid ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_notes       <= '0;
      o_notes_valid <= 1'b0;
    end else if (beat_in_hold) begin
      o_notes       <= row_now;
      o_notes_valid <= 1'b1;
    end else if (o_notes_valid && i_notes_ack) begin
      o_notes_valid <= 1'b0;
    end
  end

  // Sticky overrun: a beat found the slot still occupied and not being acked.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_overrun <= 1'b0;
    end else if (start_go) begin
      o_overrun <= 1'b0;
    end else if (beat_in_hold && o_notes_valid && !i_notes_ack) begin
      o_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_note_beat_sequencer.sv
// Bench for note_beat_sequencer: TICKS_PER_BEAT=8, LANES=5, CHART_LEN=4,
// chart ROM rows 01,02,04,10. Table-driven ack sweep over the whole song plus
// directed sequences for overrun, speed/pause timing, ack-on-beat and reset.
module tb_note_beat_sequencer;

  localparam int TPB   = 8;
  localparam int LANES = 5;
  localparam int CLEN  = 4;
  localparam int AW    = 2;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             i_start;
  logic             i_pause;
  logic [1:0]       i_speed;
  logic [AW-1:0]    o_chart_addr;
  logic [LANES-1:0] i_chart_data;
  logic             o_beat;
  logic [LANES-1:0] o_notes;
  logic             o_notes_valid;
  logic             i_notes_ack;
  logic             o_overrun;
  logic             o_done;
  logic [1:0]       o_state;

  note_beat_sequencer #(
    .TICKS_PER_BEAT(TPB),
    .LANES(LANES),
    .CHART_LEN(CLEN),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_start(i_start),
    .i_pause(i_pause),
    .i_speed(i_speed),
    .o_chart_addr(o_chart_addr),
    .i_chart_data(i_chart_data),
    .o_beat(o_beat),
    .o_notes(o_notes),
    .o_notes_valid(o_notes_valid),
    .i_notes_ack(i_notes_ack),
    .o_overrun(o_overrun),
    .o_done(o_done),
    .o_state(o_state)
  );

  // Synchronous chart ROM model
  logic [LANES-1:0] rom [CLEN];
  always @(posedge clk) i_chart_data <= rom[o_chart_addr];

  // Scoreboard
  logic [LANES-1:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_beat = 0;

  typedef struct {
    int               ack_delay;
    int               exp_gap;
    logic [LANES-1:0] exp_notes;
  } vec_t;
  vec_t vecs [4];

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_start = 1'b0;
    i_pause = 1'b0;
    i_speed = 2'd0;
    i_notes_ack = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic start_song();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    last_beat = cyc;
  endtask

  task automatic wait_beat(input string name, input int exp_gap);
    int guard;
    guard = 0;
    do begin
      step();
      guard++;
    end while (!o_beat && guard < 60);
    check({name, "_beat_seen"}, {31'd0, o_beat}, 32'd1);
    check({name, "_gap"}, cyc - last_beat, exp_gap);
    last_beat = cyc;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_addr"}, {30'd0, o_chart_addr}, 32'd0);
    check({name, "_notes"}, {27'd0, o_notes}, 32'd0);
    check({name, "_valid"}, {31'd0, o_notes_valid}, 32'd0);
    check({name, "_beat"}, {31'd0, o_beat}, 32'd0);
    check({name, "_overrun"}, {31'd0, o_overrun}, 32'd0);
    check({name, "_done"}, {31'd0, o_done}, 32'd0);
  endtask

  initial begin
    int beats;
    rom[0] = 5'h01;
    rom[1] = 5'h02;
    rom[2] = 5'h04;
    rom[3] = 5'h10;
    vecs[0] = '{ack_delay: 0, exp_gap: 8, exp_notes: 5'h01};
    vecs[1] = '{ack_delay: 1, exp_gap: 8, exp_notes: 5'h02};
    vecs[2] = '{ack_delay: 2, exp_gap: 8, exp_notes: 5'h04};
    vecs[3] = '{ack_delay: 1, exp_gap: 8, exp_notes: 5'h10};

    // Reset state
    reset = 1'b1;
    i_start = 1'b0;
    i_pause = 1'b0;
    i_speed = 2'd0;
    i_notes_ack = 1'b0;
    step();
    step();
    check_all_zero("reset");
    check("reset_state", {30'd0, o_state}, 32'd0);
    reset = 1'b0;
    step();

    // Ack while valid low is ignored
    i_notes_ack = 1'b1;
    step();
    i_notes_ack = 1'b0;
    check("idle_ack_valid", {31'd0, o_notes_valid}, 32'd0);

    // Whole song with timely acks
    start_song();
    check("start_state", {30'd0, o_state}, 32'd1);
    check("start_addr", {30'd0, o_chart_addr}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      wait_beat("song", vecs[i].exp_gap);
      exp_q.push_back(vecs[i].exp_notes);
      check("song_valid_before_load", {31'd0, o_notes_valid}, 32'd0);
      step();
      check("song_notes", {27'd0, o_notes}, {27'd0, exp_q.pop_front()});
      check("song_valid", {31'd0, o_notes_valid}, 32'd1);
      repeat (vecs[i].ack_delay) step();
      i_notes_ack = 1'b1;
      step();
      i_notes_ack = 1'b0;
      check("song_valid_cleared", {31'd0, o_notes_valid}, 32'd0);
`ifdef LOOP_CHART_EN
      if (i == 3) begin
        check("loop_done", {31'd0, o_done}, 32'd0);
        check("loop_addr", {30'd0, o_chart_addr}, 32'd0);
      end
`else
      if (i == 3) check("song_done", {31'd0, o_done}, 32'd1);
`endif
    end
    check("song_overrun", {31'd0, o_overrun}, 32'd0);
`ifdef LOOP_CHART_EN
    wait_beat("loop", 8);
    step();
    check("loop_notes", {27'd0, o_notes}, 32'h01);
    check("loop_done_after", {31'd0, o_done}, 32'd0);
`else
    beats = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (o_beat) beats++;
    end
    check("done_no_beats", beats, 0);
    check("done_held", {31'd0, o_done}, 32'd1);
`endif

    // Never ack: overrun on the second beat
    do_reset();
    start_song();
    wait_beat("ovr1", 8);
    step();
    check("ovr_notes1", {27'd0, o_notes}, 32'h01);
    wait_beat("ovr2", 8);
    check("ovr_before", {31'd0, o_overrun}, 32'd0);
    step();
    check("ovr_flag", {31'd0, o_overrun}, 32'd1);
    check("ovr_notes2", {27'd0, o_notes}, 32'h02);
    check("ovr_valid", {31'd0, o_notes_valid}, 32'd1);

    // Speed change applies at the next reload; pause delays by its length
    do_reset();
    start_song();
    i_speed = 2'd2;
    wait_beat("spd1", 8);
    wait_beat("spd2", 2);
    wait_beat("spd3", 2);
    i_pause = 1'b1;
    repeat (2) step();
    check("pause_reaches_hold", {30'd0, o_state}, 32'd2);
    repeat (3) step();
    i_pause = 1'b0;
    wait_beat("pause", 7);

    // Ack on the beat cycle, then reset mid-HOLD
    do_reset();
    start_song();
    wait_beat("ab1", 8);
    step();
    check("ab_valid1", {31'd0, o_notes_valid}, 32'd1);
    wait_beat("ab2", 8);
    i_notes_ack = 1'b1;
    step();
    i_notes_ack = 1'b0;
    check("ab_notes", {27'd0, o_notes}, 32'h02);
    check("ab_valid", {31'd0, o_notes_valid}, 32'd1);
    check("ab_overrun", {31'd0, o_overrun}, 32'd0);
    step();
    check("ab_hold", {30'd0, o_state}, 32'd2);
    reset = 1'b1;
    step();
    check_all_zero("midreset");
    check("midreset_state", {30'd0, o_state}, 32'd0);
    reset = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
